// File: rtl/block_nest_checker_if.sv
// Character stream in, nesting status out, for block_nest_checker.
// Ports: in_valid/in carry one ASCII byte per accepted cycle; result/depth/error/overflow report nesting status.
// master = byte source, slave = checker.
interface block_nest_checker_if #(
    parameter int DW = 5
);
    logic          in_valid;
    logic [7:0]    in;
    logic          result;
    logic [DW-1:0] depth;
    logic          error;
    logic          overflow;

    modport master (
        output in_valid, in,
        input  result, depth, error, overflow
    );

    modport slave (
        input  in_valid, in,
        output result, depth, error, overflow
    );
endinterface

// File: rtl/block_nest_checker.sv
// Purpose: checks begin/end (and optionally case/endcase) nesting in an ASCII stream.
// Latency: a delimiter accepted at edge N is reflected on all outputs from edge N onward.
// Backpressure: none; every valid byte is accepted, in_valid low holds all state.
// Ports: clk, reset (sync, active-high); bus.in_valid/bus.in byte input;
//        bus.result = balanced and error-free, bus.depth = open blocks,
//        bus.error / bus.overflow sticky until reset.
module block_nest_checker #(
    parameter int DEPTH   = 16,
    parameter int CASE_EN = 1,
    parameter int DW      = $clog2(DEPTH + 1)
) (
    input logic                 clk,
    input logic                 reset,
    block_nest_checker_if.slave bus
);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    logic [DW-1:0]    depth_q, depth_d;
    logic [DEPTH-1:0] stk;
    logic [7:0]       wbuf [0:6];
    // wlen saturates at 8: any word longer than 7 letters can never be a keyword.
    logic [3:0]       wlen;
    logic             error_q, error_d;
    logic             ovf_q, ovf_d;
    logic             result_q;
    logic             is_letter, commit;
    logic [7:0]       lc;
    logic             w_begin, w_end, w_case, w_endcase;
    logic             push, pop, ktype, top, push_ok;

    assign is_letter = ((bus.in >= 8'h61) && (bus.in <= 8'h7a)) ||
                       ((bus.in >= 8'h41) && (bus.in <= 8'h5a));
    // Setting bit 5 folds upper-case letters onto lower-case.
    assign lc     = bus.in | 8'h20;
    assign commit = bus.in_valid && !is_letter;

    // wlen is checked exactly, so prefixes and extensions never match.
    assign w_begin   = (wlen == 4'd5) && (wbuf[0] == "b") && (wbuf[1] == "e") &&
                       (wbuf[2] == "g") && (wbuf[3] == "i") && (wbuf[4] == "n");
    assign w_end     = (wlen == 4'd3) && (wbuf[0] == "e") && (wbuf[1] == "n") &&
                       (wbuf[2] == "d");
    assign w_case    = (CASE_EN != 0) && (wlen == 4'd4) && (wbuf[0] == "c") &&
                       (wbuf[1] == "a") && (wbuf[2] == "s") && (wbuf[3] == "e");
    assign w_endcase = (CASE_EN != 0) && (wlen == 4'd7) && (wbuf[0] == "e") &&
                       (wbuf[1] == "n") && (wbuf[2] == "d") && (wbuf[3] == "c") &&
                       (wbuf[4] == "a") && (wbuf[5] == "s") && (wbuf[6] == "e");

    assign push  = w_begin || w_case;
    assign pop   = w_end || w_endcase;
    assign ktype = w_case || w_endcase;   // B = 0, C = 1

    // Top-of-stack read; value is irrelevant when depth is 0 (pop errors first).
    always_comb begin
        top = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i) == depth_q - 1'b1) begin
                top = stk[i];
            end
        end
    end

    always_comb begin
        depth_d = depth_q;
        error_d = error_q;
        ovf_d   = ovf_q;
        push_ok = 1'b0;
        // Once error is set the stack and depth are frozen.
        if (commit && !error_q) begin
            if (push) begin
                if (depth_q == FULL) begin
                    ovf_d   = 1'b1;
                    error_d = 1'b1;
                end else begin
                    push_ok = 1'b1;
                    depth_d = depth_q + 1'b1;
                end
            end else if (pop) begin
                if ((depth_q == '0) || (top != ktype)) begin
                    error_d = 1'b1;
                end else begin
                    depth_d = depth_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q  <= '0;
            error_q  <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= 1'b1;
            stk      <= '0;
            wlen     <= '0;
            for (int i = 0; i < 7; i++) begin
                wbuf[i] <= '0;
            end
        end else if (bus.in_valid) begin
            if (is_letter) begin
                if (wlen < 4'd7) begin
                    wbuf[wlen[2:0]] <= lc;
                end
                if (wlen != 4'd8) begin
                    wlen <= wlen + 4'd1;
                end
            end else begin
                wlen     <= '0;
                depth_q  <= depth_d;
                error_q  <= error_d;
                ovf_q    <= ovf_d;
                result_q <= (depth_d == '0) && !error_d;
                for (int i = 0; i < DEPTH; i++) begin
                    if (push_ok && (DW'(i) == depth_q)) begin
                        stk[i] <= ktype;
                    end
                end
            end
        end
    end

    assign bus.result   = result_q;
    assign bus.depth    = depth_q;
    assign bus.error    = error_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: three instances (DEPTH 16/CASE_EN 1, DEPTH 2/CASE_EN 1,
// DEPTH 16/CASE_EN 0) share one stimulus stream and are compared each cycle against
// a string/array model of the nesting rules.
module tb_block_nest_checker;
    logic       clk = 1'b0;
    logic       reset;
    logic       iv;
    logic [7:0] ib;
    bit         chk_en = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    block_nest_checker_if #(.DW(5)) if0 ();
    block_nest_checker_if #(.DW(2)) if1 ();
    block_nest_checker_if #(.DW(5)) if2 ();

    assign if0.in_valid = iv;
    assign if0.in       = ib;
    assign if1.in_valid = iv;
    assign if1.in       = ib;
    assign if2.in_valid = iv;
    assign if2.in       = ib;

    block_nest_checker #(.DEPTH(16), .CASE_EN(1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    block_nest_checker #(.DEPTH(2),  .CASE_EN(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    block_nest_checker #(.DEPTH(16), .CASE_EN(0)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    // Reference model: current word as a string, stack as an array plus count.
    int    lim [3] = '{16, 2, 16};
    int    cen [3] = '{1, 1, 0};
    string m_word [3];
    int    m_dep [3];
    bit    m_err [3];
    bit    m_ovf [3];
    bit    m_st [3][256];

    function automatic int m_res(int k);
        return (m_dep[k] == 0 && !m_err[k]) ? 1 : 0;
    endfunction

    // f: 0 result, 1 depth, 2 error, 3 overflow
    function automatic int dut_get(int k, int f);
        case (k)
            0: case (f)
                0: return int'(if0.result);
                1: return int'(if0.depth);
                2: return int'(if0.error);
                default: return int'(if0.overflow);
            endcase
            1: case (f)
                0: return int'(if1.result);
                1: return int'(if1.depth);
                2: return int'(if1.error);
                default: return int'(if1.overflow);
            endcase
            default: case (f)
                0: return int'(if2.result);
                1: return int'(if2.depth);
                2: return int'(if2.error);
                default: return int'(if2.overflow);
            endcase
        endcase
    endfunction

    task automatic check(string nm, int k, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d at %0t: got %0d want %0d", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_step(int k, bit r, bit v, byte c);
        string w;
        int    t;
        bit    is_push, is_pop;
        if (r) begin
            m_word[k] = "";
            m_dep[k]  = 0;
            m_err[k]  = 0;
            m_ovf[k]  = 0;
            return;
        end
        if (!v) return;
        if ((c >= "a" && c <= "z") || (c >= "A" && c <= "Z")) begin
            m_word[k] = $sformatf("%s%c", m_word[k], c);
            return;
        end
        w = m_word[k].tolower();
        m_word[k] = "";
        if (m_err[k]) return;
        is_push = (w == "begin") || (cen[k] != 0 && w == "case");
        is_pop  = (w == "end") || (cen[k] != 0 && w == "endcase");
        t = (w == "case" || w == "endcase") ? 1 : 0;
        if (is_push) begin
            if (m_dep[k] == lim[k]) begin
                m_ovf[k] = 1;
                m_err[k] = 1;
            end else begin
                m_st[k][m_dep[k]] = t[0];
                m_dep[k]++;
            end
        end else if (is_pop) begin
            if (m_dep[k] == 0 || int'(m_st[k][m_dep[k]-1]) != t) m_err[k] = 1;
            else m_dep[k]--;
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check("result",   k, dut_get(k, 0), m_res(k));
                check("depth",    k, dut_get(k, 1), m_dep[k]);
                check("error",    k, dut_get(k, 2), int'(m_err[k]));
                check("overflow", k, dut_get(k, 3), int'(m_ovf[k]));
            end
        end
    end

    task automatic cyc(bit r, bit v, byte c);
        reset = r;
        iv    = v;
        ib    = c;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r, v, c);
        @(negedge clk);
    endtask

    task automatic send(string s);
        for (int i = 0; i < s.len(); i++) cyc(1'b0, 1'b1, s[i]);
    endtask

    // Hand-computed expectations: pin both the model and the DUT.
    task automatic pin(int k, int d, int r, int e, int o, string nm);
        check({nm, ".mdl_depth"}, k, m_dep[k], d);
        check({nm, ".mdl_result"}, k, m_res(k), r);
        check({nm, ".mdl_error"}, k, int'(m_err[k]), e);
        check({nm, ".mdl_ovf"}, k, int'(m_ovf[k]), o);
        check({nm, ".dut_depth"}, k, dut_get(k, 1), d);
        check({nm, ".dut_result"}, k, dut_get(k, 0), r);
        check({nm, ".dut_error"}, k, dut_get(k, 2), e);
        check({nm, ".dut_ovf"}, k, dut_get(k, 3), o);
    endtask

    string words [12] = '{"begin", "end", "case", "endcase", "BEGIN", "EndCase",
                          "beg", "endr", "beginx", "endcasex", "n", "end"};
    string delims = " ;\n1(";

    initial begin
        reset = 1'b1;
        iv    = 1'b0;
        ib    = 8'h00;
        cyc(1'b1, 1'b0, 8'h00);
        chk_en = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        pin(0, 0, 1, 0, 0, "reset");

        send("begin "); pin(0, 1, 0, 0, 0, "bb1");
        send("begin "); pin(0, 2, 0, 0, 0, "bb2");
        send("end ");   pin(0, 1, 0, 0, 0, "bb3");
        send("end ");   pin(0, 0, 1, 0, 0, "bb4");

        cyc(1'b1, 1'b0, 8'h00);
        send("begin case end ");
        pin(0, 2, 0, 1, 0, "mismatch");
        pin(2, 0, 1, 0, 0, "nocase");
        send("endcase end ");
        pin(0, 2, 0, 1, 0, "sticky");
        pin(2, 0, 0, 1, 0, "nocase_under");

        cyc(1'b1, 1'b0, 8'h00);
        send("BeGiN endr "); pin(0, 1, 0, 0, 0, "mixcase");
        send("end ");        pin(0, 0, 1, 0, 0, "mixcase_end");

        cyc(1'b1, 1'b0, 8'h00);
        send("end ");        pin(0, 0, 0, 1, 0, "underflow");
        cyc(1'b1, 1'b0, 8'h00);
        pin(0, 0, 1, 0, 0, "underflow_rst");

        send("begin begin begin ");
        pin(1, 2, 0, 1, 1, "ovf2");
        pin(0, 3, 0, 0, 0, "deep3");

        cyc(1'b1, 1'b0, 8'h00);
        repeat (16) send("begin ");
        pin(0, 16, 0, 0, 0, "full16");
        send("begin ");
        pin(0, 16, 0, 1, 1, "ovf16");

        cyc(1'b1, 1'b0, 8'h00);
        send("begi");
        repeat (5) cyc(1'b0, 1'b0, " ");
        send("n ");
        pin(0, 1, 0, 0, 0, "gap");
        cyc(1'b1, 1'b0, 8'h00);
        send("begi");
        cyc(1'b1, 1'b0, 8'h00);
        send("n ");
        pin(0, 0, 1, 0, 0, "rst_midword");
        send("begi");
        cyc(1'b1, 1'b1, "n");
        send(" ");
        pin(0, 0, 1, 0, 0, "rst_discard");

        for (int n = 0; n < 1500; n++) begin
            string w;
            if ($urandom_range(0, 59) == 0) cyc(1'b1, 1'($urandom_range(0, 1)), byte'($urandom_range(0, 255)));
            w = words[$urandom_range(0, 11)];
            for (int i = 0; i < w.len(); i++) begin
                if ($urandom_range(0, 5) == 0) cyc(1'b0, 1'b0, byte'($urandom_range(0, 255)));
                cyc(1'b0, 1'b1, w[i]);
            end
            repeat ($urandom_range(1, 2)) cyc(1'b0, 1'b1, delims[$urandom_range(0, 4)]);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
